// File: rtl/ntru_hrss_pkg.sv
// Shared constants and types for the NTRU-HRSS Rq0 datapath.
package ntru_hrss_pkg;

   localparam int N        = 701;
   localparam int LOGQ     = 13;
   localparam int NBYTES   = 1138;
   localparam int PAD_BITS = 4;

   localparam logic [LOGQ-1:0] Q_MASK = '1;

   typedef logic [LOGQ-1:0] coef_t;

   typedef enum logic {
      RUN,
      LAST
   } state_t;

endpackage

// File: rtl/unpack_rq0_stream_bitrev8.sv
// Combinational byte bit-order reversal; frame bytes are packed MSB-first.
module unpack_rq0_stream_bitrev8 (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         dout[i] = din[7-i];
      end
   end

endmodule

// File: rtl/unpack_rq0_stream.sv
// Byte-serial unpacker for 13-bit Rq0 ciphertext frames; the final coefficient
// is rebuilt as the negated running sum because Rq0 elements sum to zero.
module unpack_rq0_stream
   import ntru_hrss_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_byte,
   output logic        coef_valid,
   input  logic        coef_ready,
   output logic [12:0] coef_data,
   output logic [9:0]  coef_idx,
   output logic        coef_last,
   output logic        fmt_err,
   output logic        frame_done
);

   state_t      state, state_next;
   logic [19:0] bitbuf;
   logic [4:0]  fill;
   logic [10:0] byte_cnt;
   coef_t       sum;
   logic [7:0]  rev_byte;
   logic        byte_acc, coef_acc;

   unpack_rq0_stream_bitrev8 u_bitrev (
      .din  (in_byte),
      .dout (rev_byte)
   );

   // Outputs are decoded purely from registers; handshakes only steer the next state.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      coef_valid = 1'b0;
      coef_data  = '0;
      coef_last  = 1'b0;
      case (state)
         RUN: begin
            in_ready   = (fill < 5'(LOGQ)) && (byte_cnt < 11'(NBYTES));
            coef_valid = (fill >= 5'(LOGQ));
            coef_data  = bitbuf[LOGQ-1:0];
            if (coef_valid && coef_ready && (coef_idx == 10'(N-2))) begin
               state_next = LAST;
            end
         end
         LAST: begin
            coef_valid = 1'b1;
            coef_data  = Q_MASK & (~sum + coef_t'(1));
            coef_last  = 1'b1;
            if (coef_ready) begin
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   assign byte_acc = in_valid && in_ready;
   assign coef_acc = coef_valid && coef_ready;

   // Accept and emit never coincide, since one needs fill < 13 and the other fill >= 13.
   // Taking coefficient 699 leaves exactly the 4 pad bits at the bottom of bitbuf.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= RUN;
         bitbuf     <= '0;
         fill       <= '0;
         byte_cnt   <= '0;
         coef_idx   <= '0;
         sum        <= '0;
         fmt_err    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         frame_done <= 1'b0;
         if (state == LAST) begin
            if (coef_ready) begin
               bitbuf     <= '0;
               fill       <= '0;
               byte_cnt   <= '0;
               coef_idx   <= '0;
               sum        <= '0;
               fmt_err    <= 1'b0;
               frame_done <= 1'b1;
            end
         end else if (byte_acc) begin
            bitbuf   <= bitbuf | ({12'd0, rev_byte} << fill);
            fill     <= fill + 5'd8;
            byte_cnt <= byte_cnt + 11'd1;
         end else if (coef_acc) begin
            bitbuf   <= bitbuf >> LOGQ;
            fill     <= fill - 5'(LOGQ);
            sum      <= sum + coef_data;
            coef_idx <= coef_idx + 10'd1;
            if (coef_idx == 10'(N-2)) begin
               fmt_err <= (bitbuf[LOGQ +: PAD_BITS] != '0);
            end
         end
      end
   end

endmodule
